// File: rtl/gmii_tx_arbiter_if.sv
// gmii_tx_arbiter_if
//   Bundle of the two sender handshakes and the shared GMII transmit port.
//   master : sender/PHY side (drives req/txctl/txd, observes gnt and PHY bus)
//   slave  : arbiter side (observes req/txctl/txd, drives gnt and PHY bus)
//   Signals: req0/req1, gnt0/gnt1, txctl0/txctl1, txd0/txd1 (8b),
//            gmii_txctl, gmii_txd (8b).
interface gmii_tx_arbiter_if;
  logic       req0;
  logic       req1;
  logic       gnt0;
  logic       gnt1;
  logic       txctl0;
  logic       txctl1;
  logic [7:0] txd0;
  logic [7:0] txd1;
  logic       gmii_txctl;
  logic [7:0] gmii_txd;

  modport master (
    output req0, req1, txctl0, txctl1, txd0, txd1,
    input  gnt0, gnt1, gmii_txctl, gmii_txd
  );

  modport slave (
    input  req0, req1, txctl0, txctl1, txd0, txd1,
    output gnt0, gnt1, gmii_txctl, gmii_txd
  );
endinterface

// File: rtl/gmii_tx_arbiter.sv
// gmii_tx_arbiter
//   Round-robin scheduler sharing one GMII transmit port between two UDP
//   line senders. The granted sender's txctl/txd reach the PHY through one
//   register stage; a minimum inter-frame gap is enforced between grants.
//   Optional grant reclaim is built when GMII_ARB_TIMEOUT_EN is defined.
// Ports
//   clk            in   GMII transmit clock
//   rst_n          in   synchronous active-low reset
//   bus            if   slave side of gmii_tx_arbiter_if (req/gnt/txctl/txd, PHY)
//   o_busy         out  state is not IDLE
//   o_frame_cnt0/1 out  completed frames per channel, wrapping
//   o_timeout_cnt  out  revoked grants, saturating (0 without the macro)
// Parameters
//   IFG_CYCLES     idle cycles spent in IFG (1..255)
//   GRANT_TIMEOUT  unused-grant limit in cycles (2..65535, macro builds only)
//
// state | meaning
// IDLE  | no grant, arbitrate among pending requests
// GRANT | gnt high, waiting for the granted sender's txctl
// SEND  | forwarding the granted sender's frame
// IFG   | gnt low, counting out the inter-frame gap
module gmii_tx_arbiter #(
  parameter int IFG_CYCLES    = 12,
  parameter int GRANT_TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  gmii_tx_arbiter_if.slave    bus,
  output logic                o_busy,
  output logic [15:0]         o_frame_cnt0,
  output logic [15:0]         o_frame_cnt1,
  output logic [7:0]          o_timeout_cnt
);

  if (IFG_CYCLES < 1 || IFG_CYCLES > 255) begin : g_bad_ifg
    $error("IFG_CYCLES must be 1..255");
  end
  if (GRANT_TIMEOUT < 2 || GRANT_TIMEOUT > 65535) begin : g_bad_timeout
    $error("GRANT_TIMEOUT must be 2..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_SEND,
    S_IFG
  } state_t;

  localparam logic [7:0] IFG_LOAD = 8'(IFG_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_sel;
  logic        r_last;
  logic [7:0]  r_ifg_cnt;
  logic        r_gmii_txctl;
  logic [7:0]  r_gmii_txd;
  logic [15:0] r_frame_cnt0;
  logic [15:0] r_frame_cnt1;

  logic        w_any_req;
  logic        w_win;
  logic        w_txctl_sel;
  logic [7:0]  w_txd_sel;
  logic        w_fwd;
  logic        w_revoke;

  assign w_any_req   = bus.req0 | bus.req1;
  assign w_txctl_sel = r_sel ? bus.txctl1 : bus.txctl0;
  assign w_txd_sel   = r_sel ? bus.txd1 : bus.txd0;
  assign w_fwd       = (r_state == S_GRANT) || (r_state == S_SEND);

  // On a tie the channel not served last wins; otherwise the lone requester.
  always_comb begin
    w_win = bus.req1;
    if (bus.req0 && bus.req1) begin
      w_win = ~r_last;
    end
  end

`ifdef GMII_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LOAD = 16'(GRANT_TIMEOUT - 1);

  logic [15:0] r_to_cnt;
  logic [7:0]  r_timeout_cnt;

  // A txctl seen on the last allowed cycle still wins over the revoke.
  assign w_revoke = (r_state == S_GRANT) && (r_to_cnt == 16'd0) && !w_txctl_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_to_cnt      <= 16'd0;
      r_timeout_cnt <= 8'd0;
    end else begin
      if (r_state == S_IDLE && w_any_req) begin
        r_to_cnt <= TO_LOAD;
      end else if (r_state == S_GRANT && r_to_cnt != 16'd0) begin
        r_to_cnt <= r_to_cnt - 16'd1;
      end
      if (w_revoke && r_timeout_cnt != 8'hFF) begin
        r_timeout_cnt <= r_timeout_cnt + 8'd1;
      end
    end
  end

  assign o_timeout_cnt = r_timeout_cnt;
`else
  assign w_revoke      = 1'b0;
  assign o_timeout_cnt = 8'h00;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) w_state_nxt = S_GRANT;
      end
      S_GRANT: begin
        if (w_txctl_sel)   w_state_nxt = S_SEND;
        else if (w_revoke) w_state_nxt = S_IFG;
      end
      S_SEND: begin
        if (!w_txctl_sel) w_state_nxt = S_IFG;
      end
      S_IFG: begin
        if (r_ifg_cnt == 8'd0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sel        <= 1'b0;
      r_last       <= 1'b1;
      r_ifg_cnt    <= 8'd0;
      r_gmii_txctl <= 1'b0;
      r_gmii_txd   <= 8'h00;
      r_frame_cnt0 <= 16'd0;
      r_frame_cnt1 <= 16'd0;
    end else begin
      r_state <= w_state_nxt;

      // Pointer moves on every grant, including ones later revoked.
      if (r_state == S_IDLE && w_any_req) begin
        r_sel  <= w_win;
        r_last <= w_win;
      end

      if (w_state_nxt == S_IFG && r_state != S_IFG) begin
        r_ifg_cnt <= IFG_LOAD;
      end else if (r_state == S_IFG && r_ifg_cnt != 8'd0) begin
        r_ifg_cnt <= r_ifg_cnt - 8'd1;
      end

      if (r_state == S_SEND && !w_txctl_sel) begin
        if (r_sel) r_frame_cnt1 <= r_frame_cnt1 + 16'd1;
        else       r_frame_cnt0 <= r_frame_cnt0 + 16'd1;
      end

      if (w_fwd) begin
        r_gmii_txctl <= w_txctl_sel;
        r_gmii_txd   <= w_txd_sel;
      end else begin
        r_gmii_txctl <= 1'b0;
        r_gmii_txd   <= 8'h00;
      end
    end
  end

  assign bus.gnt0       = w_fwd && !r_sel;
  assign bus.gnt1       = w_fwd && r_sel;
  assign bus.gmii_txctl = r_gmii_txctl;
  assign bus.gmii_txd   = r_gmii_txd;
  assign o_busy         = (r_state != S_IDLE);
  assign o_frame_cnt0   = r_frame_cnt0;
  assign o_frame_cnt1   = r_frame_cnt1;

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// tb_gmii_tx_arbiter
//   Scoreboard bench: every byte driven by a granted sender is queued with
//   its drive cycle and must appear on the PHY exactly one cycle later; every
//   expected grant is queued and matched against gnt rising edges.
//   Timeout scenario is compiled only with GMII_ARB_TIMEOUT_EN.
module tb_gmii_tx_arbiter;
  localparam int IFG = 12;
  localparam int GTO = 16;

  logic        clk;
  logic        rst_n;
  logic        o_busy;
  logic [15:0] o_frame_cnt0;
  logic [15:0] o_frame_cnt1;
  logic [7:0]  o_timeout_cnt;

  gmii_tx_arbiter_if bus ();

  gmii_tx_arbiter #(
    .IFG_CYCLES   (IFG),
    .GRANT_TIMEOUT(GTO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .o_busy       (o_busy),
    .o_frame_cnt0 (o_frame_cnt0),
    .o_frame_cnt1 (o_frame_cnt1),
    .o_timeout_cnt(o_timeout_cnt)
  );

  typedef struct {
    logic [7:0] b;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   gq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   mon_en   = 0;
  bit   noise_stop;

  initial clk = 1'b0;
  always #4 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // PHY-side monitor: data/latency scoreboard, idle zeroes, gap, one-hot gnt.
  bit   seen_frame = 0;
  int   low_run    = 0;
  logic prev_g0    = 1'b0;
  logic prev_g1    = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus.gmii_txctl) begin
        if (sb_q.size() == 0) begin
          chk("data_unexpected", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("data", bus.gmii_txd, e.b);
          chk("latency", cyc - e.cyc, 1);
        end
        if (seen_frame && low_run > 0) chk("ifg_gap_min", (low_run >= IFG + 2), 1);
        low_run    = 0;
        seen_frame = 1;
      end else begin
        chk("idle_txd", bus.gmii_txd, 8'h00);
        low_run++;
      end
      chk("gnt_onehot", bus.gnt0 & bus.gnt1, 0);
      if (bus.gnt0 && !prev_g0) begin
        if (gq.size() == 0) chk("gnt_unexpected0", 1, 0);
        else                chk("gnt_order", 0, gq.pop_front());
      end
      if (bus.gnt1 && !prev_g1) begin
        if (gq.size() == 0) chk("gnt_unexpected1", 1, 0);
        else                chk("gnt_order", 1, gq.pop_front());
      end
      if (!rst_n) begin
        seen_frame = 0;
        low_run    = 0;
      end
    end
    prev_g0 = bus.gnt0;
    prev_g1 = bus.gnt1;
  end

  task automatic set_tx(input int ch, input logic c, input logic [7:0] d);
    if (ch == 0) begin
      bus.txctl0 = c;
      bus.txd0   = d;
    end else begin
      bus.txctl1 = c;
      bus.txd1   = d;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n      = 1'b0;
    bus.req0   = 1'b0;
    bus.req1   = 1'b0;
    set_tx(0, 1'b0, 8'h00);
    set_tx(1, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_gnt(input int ch);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((ch == 0) ? bus.gnt0 : bus.gnt1) begin
        ok = 1;
        break;
      end
    end
    chk($sformatf("gnt%0d_wait", ch), ok, 1);
  endtask

  // Drives len bytes starting at the next edge; txctl drops right after.
  task automatic drive_frame(input int ch, input int len);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      b = 8'($urandom);
      set_tx(ch, 1'b1, b);
      sb_q.push_back('{b: b, cyc: cyc});
    end
    @(posedge clk); #1;
    set_tx(ch, 1'b0, 8'h00);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int ch;
    int n;
    logic [7:0] b;
    rst_n = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    set_tx(0, 1'b0, 8'h00);
    set_tx(1, 1'b0, 8'h00);
    do_reset();
    @(negedge clk);
    mon_en = 1;

    // Reset values
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_txctl", bus.gmii_txctl, 0);
    chk("rst_txd", bus.gmii_txd, 8'h00);
    chk("rst_busy", o_busy, 0);
    chk("rst_fc0", o_frame_cnt0, 0);
    chk("rst_fc1", o_frame_cnt1, 0);
    chk("rst_tocnt", o_timeout_cnt, 0);

    // Single request, 100-byte frame two cycles after gnt0
    @(posedge clk); #1;
    bus.req0 = 1'b1;
    gq.push_back(0);
    @(negedge clk);
    chk("gnt_lat_early", bus.gnt0, 0);
    @(negedge clk);
    chk("gnt_lat", bus.gnt0, 1);
    chk("busy_grant", o_busy, 1);
    bus.req0 = 1'b0;
    @(posedge clk);
    drive_frame(0, 100);
    repeat (3) @(negedge clk);
    chk("single_fc0", o_frame_cnt0, 1);
    chk("single_fc1", o_frame_cnt1, 0);
    repeat (IFG + 2) @(posedge clk);
    chk("single_idle_busy", o_busy, 0);

    // Simultaneous requests from reset: channel 0 first
    do_reset();
    @(posedge clk); #1;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    gq.push_back(0);
    gq.push_back(1);
    wait_gnt(0);
    bus.req0 = 1'b0;
    drive_frame(0, 20);
    wait_gnt(1);
    bus.req1 = 1'b0;
    drive_frame(1, 20);
    repeat (IFG + 4) @(posedge clk);

    // Fairness: both requests held for 10 frames
    do_reset();
    @(posedge clk); #1;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int i = 0; i < 10; i++) gq.push_back(i % 2);
    ch = 0;
    for (int i = 0; i < 10; i++) begin
      wait_gnt(i % 2);
      ch = i % 2;
      drive_frame(ch, 6 + i);
      if (i == 9) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end else begin
        n = 0;
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          n++;
          if ((ch == 0) ? bus.gnt1 : bus.gnt0) break;
        end
        chk("ifg_to_gnt", n, IFG + 3);
      end
    end
    repeat (IFG + 4) @(negedge clk);
    chk("fair_fc0", o_frame_cnt0, 5);
    chk("fair_fc1", o_frame_cnt1, 5);

    // Isolation: channel 1 toggles randomly while channel 0 owns the port
    noise_stop = 0;
    fork
      begin
        while (!noise_stop) begin
          @(posedge clk); #1;
          bus.txctl1 = 1'($urandom);
          bus.txd1   = 8'($urandom);
        end
        bus.txctl1 = 1'b0;
        bus.txd1   = 8'h00;
      end
      begin
        @(posedge clk); #1;
        bus.req0 = 1'b1;
        gq.push_back(0);
        wait_gnt(0);
        bus.req0 = 1'b0;
        drive_frame(0, 30);
        repeat (IFG + 4) @(posedge clk);
        noise_stop = 1;
      end
    join
    chk("iso_fc0", o_frame_cnt0, 6);
    chk("iso_fc1", o_frame_cnt1, 5);

`ifdef GMII_ARB_TIMEOUT_EN
    // Unused grant on channel 1 is revoked; pending channel 0 then served
    do_reset();
    @(posedge clk); #1;
    bus.req1 = 1'b1;
    gq.push_back(1);
    gq.push_back(0);
    wait_gnt(1);
    bus.req1 = 1'b0;
    bus.req0 = 1'b1;
    n = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!bus.gnt1) break;
      n++;
    end
    chk("timeout_gnt_len", n, GTO);
    chk("timeout_cnt", o_timeout_cnt, 1);
    chk("timeout_fc1", o_frame_cnt1, 0);
    wait_gnt(0);
    bus.req0 = 1'b0;
    drive_frame(0, 10);
    repeat (IFG + 4) @(negedge clk);
    chk("timeout_fc0", o_frame_cnt0, 1);
    chk("timeout_cnt_hold", o_timeout_cnt, 1);
`else
    chk("timeout_cnt_off", o_timeout_cnt, 0);
`endif

    // Reset during byte 40 of a frame
    @(posedge clk); #1;
    bus.req0 = 1'b1;
    gq.push_back(0);
    wait_gnt(0);
    bus.req0 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      b = 8'($urandom);
      set_tx(0, 1'b1, b);
      if (i == 39) rst_n = 1'b0;
      else         sb_q.push_back('{b: b, cyc: cyc});
    end
    @(negedge clk);
    @(negedge clk);
    chk("mrst_txctl", bus.gmii_txctl, 0);
    chk("mrst_gnt0", bus.gnt0, 0);
    chk("mrst_gnt1", bus.gnt1, 0);
    chk("mrst_busy", o_busy, 0);
    chk("mrst_fc0", o_frame_cnt0, 0);
    @(posedge clk); #1;
    set_tx(0, 1'b0, 8'h00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mrst_fc0_after", o_frame_cnt0, 0);
    chk("mrst_busy_after", o_busy, 0);

    chk("sb_empty", sb_q.size(), 0);
    chk("gq_empty", gq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
